// File: rtl/spi_pkg.sv
// Shared types and width helpers for the burst SPI register-file target.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA,
        DONE
    } fsm_state_t;

    localparam int CPOL = 1;
    localparam int CPHA = 0;

    function automatic int cmd_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one-cycle rise/fall pulses on the synced level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Resetting to 0 keeps a CS that is already low from looking like a new frame.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else if (ena) begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral_burst.sv
// SPI target with burst auto-increment, read-strobe prefetch and abort detection.
module spi_peripheral_burst
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] status,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              re,
    input  logic [DATA_W-1:0] rdata,
    output logic              wr_rdn,
    output logic              busy,
    output logic              frame_err
);

    localparam int CMD_W  = cmd_w(ADDR_W);
    localparam int TX_W   = max_w(CMD_W, DATA_W);
    localparam int CNT_W  = $clog2(TX_W + 1);
    localparam int SH_CMD = TX_W - CMD_W;
    localparam int SH_DAT = TX_W - DATA_W;

    logic sclk_s_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_s;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .din   (spi_clk),
        .level (sclk_s_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .din   (spi_cs_n),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .din   (spi_mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    fsm_state_t        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [TX_W-2:0]   rx_q, rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              skip_q, skip_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              ld_q, ld_d;
    logic              wr_rdn_q, wr_rdn_d;
    logic              ferr_q, ferr_d;

    logic              cs_low;
    logic              swap;
    logic              sample;
    logic              change;
    logic              active;
    logic              last;
    logic [TX_W-1:0]   shifted;
    logic [CMD_W-1:0]  cmd_word;
    logic [DATA_W-1:0] data_word;
    logic [TX_W-1:0]   status_tx;
    logic [TX_W-1:0]   rdata_tx;

    // A CS rise in the same cycle as a sample edge must still see that edge.
    assign cs_low    = ~cs_s | cs_rise;
    assign swap      = mode_q[CPOL] ^ mode_q[CPHA];
    assign sample    = cs_low & (swap ? sclk_fall : sclk_rise);
    assign change    = cs_low & (swap ? sclk_rise : sclk_fall);
    assign active    = (state_q == CMD) || (state_q == WR_DATA)
                    || (state_q == RD_DATA);
    assign last      = (state_q == CMD) ? (cnt_q == CNT_W'(CMD_W - 1))
                                        : (cnt_q == CNT_W'(DATA_W - 1));
    assign shifted   = {rx_q, mosi_s};
    assign cmd_word  = shifted[CMD_W-1:0];
    assign data_word = shifted[DATA_W-1:0];
    assign status_tx = TX_W'(CMD_W'(status)) << SH_CMD;
    assign rdata_tx  = TX_W'(rdata) << SH_DAT;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        skip_d   = skip_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_rdn_d = wr_rdn_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        ld_d     = re_q;
        ferr_d   = 1'b0;

        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        if (active && change) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                tx_d = {tx_q[TX_W-2:0], 1'b0};
            end
        end

        // A freshly loaded word already shows its MSB, so the next change edge must not shift.
        if (ld_q && (state_q == RD_DATA)) begin
            tx_d   = rdata_tx;
            skip_d = 1'b1;
        end

        if (active && sample) begin
            rx_d  = shifted[TX_W-2:0];
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                if (state_q == CMD) begin
                    addr_d   = cmd_word[ADDR_W-1:0];
                    wr_rdn_d = cmd_word[CMD_W-1];
                    re_d     = ~cmd_word[CMD_W-1];
                    state_d  = cmd_word[CMD_W-1] ? WR_DATA : RD_DATA;
                end else if (state_q == WR_DATA) begin
                    wdata_d = data_word;
                    we_d    = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    re_d   = 1'b1;
                end
            end
        end

        if (active && cs_rise) begin
            state_d = DONE;
            ferr_d  = (cnt_d != '0);
            cnt_d   = '0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    mode_d  = mode;
                    tx_d    = status_tx;
                    rx_d    = '0;
                    cnt_d   = '0;
                    skip_d  = mode[CPHA];
                end
            end
            DONE: begin
                state_d = IDLE;
                tx_d    = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
            skip_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            ld_q     <= 1'b0;
            wr_rdn_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            skip_q   <= skip_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            ld_q     <= ld_d;
            wr_rdn_q <= wr_rdn_d;
            ferr_q   <= ferr_d;
        end
    end

    assign spi_miso  = tx_q[TX_W-1];
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign we        = we_q;
    assign re        = re_q;
    assign wr_rdn    = wr_rdn_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_peripheral_burst.sv
// Directed bench for spi_peripheral_burst: modes, bursts, abort, reset, enable.
module tb_spi_peripheral_burst;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [1:0] mode;
    logic [7:0] status;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic [7:0] rdata = 8'h00;
    logic       wr_rdn;
    logic       busy;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    logic [6:0] we_addr[$];
    logic [7:0] we_data[$];
    logic [6:0] re_addr[$];
    int         ferr_n = 0;
    logic [1:0] cur_mode;

    always #5 clk = ~clk;

    spi_peripheral_burst dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mode      (mode),
        .status    (status),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .wr_rdn    (wr_rdn),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Register bank stand-in: answers a read strobe with addr^0xFF one clk later.
    always @(negedge clk) begin
        if (re) rdata <= {1'b0, addr} ^ 8'hFF;
    end

    always @(negedge clk) begin
        if (we) begin
            we_addr.push_back(addr);
            we_data.push_back(wdata);
        end
        if (re) re_addr.push_back(addr);
        if (frame_err) ferr_n++;
    end

    task automatic spi_begin(input logic [1:0] m);
        cur_mode = m;
        mode     = m;
        spi_clk  = m[1];
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b0;
    endtask

    task automatic spi_bits(input int n, input logic [31:0] tx,
                            output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cur_mode[0]) spi_mosi = tx[i];
            repeat (H) @(negedge clk);
            spi_clk = ~cur_mode[1];
            if (cur_mode[0]) spi_mosi = tx[i];
            else rx = {rx[30:0], spi_miso};
            repeat (H) @(negedge clk);
            spi_clk = cur_mode[1];
            if (cur_mode[0]) rx = {rx[30:0], spi_miso};
        end
    endtask

    task automatic spi_end();
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (H) @(negedge clk);
        spi_mosi = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] o;
        rstb = 1'b0;
        ena = 1'b1;
        spi_clk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        mode = 2'b00;
        status = 8'h5A;
        repeat (4) @(negedge clk);
        o = {spi_miso, addr, wdata, we, re, wr_rdn, busy, frame_err, 5'b0};
        total++;
        if (o !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", o);
        end
        rstb = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if ({busy, spi_miso} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=00", {busy, spi_miso});
        end
    endtask

    task automatic test_write_mode0();
        logic [31:0] r;
        int w0 = we_addr.size();
        int f0 = ferr_n;
        spi_begin(2'b00);
        spi_bits(8, 32'h83, r);
        total++;
        if (r[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL w0_status got=%h exp=5a", r[7:0]);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL w0_busy_mid got=%b exp=1", busy);
        end
        spi_bits(8, 32'hC4, r);
        spi_end();
        total++;
        if (we_addr.size() - w0 !== 1) begin
            bad++;
            $display("FAIL w0_we_count got=%0d exp=1", we_addr.size() - w0);
        end
        total++;
        if (we_addr[w0] !== 7'h03 || we_data[w0] !== 8'hC4) begin
            bad++;
            $display("FAIL w0_we got=%h/%h exp=03/c4", we_addr[w0], we_data[w0]);
        end
        total++;
        if ({busy, wr_rdn} !== 2'b01 || ferr_n != f0) begin
            bad++;
            $display("FAIL w0_end got=%b%b ferr=%0d exp=01 ferr=0",
                     busy, wr_rdn, ferr_n - f0);
        end
    endtask

    task automatic test_burst_write_mode3();
        logic [31:0] r;
        logic [6:0] ea[3] = '{7'h7E, 7'h7F, 7'h00};
        logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
        int w0 = we_addr.size();
        spi_begin(2'b11);
        spi_bits(8, 32'hFE, r);
        total++;
        if (r[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL bw_status got=%h exp=5a", r[7:0]);
        end
        spi_bits(24, 32'h112233, r);
        spi_end();
        total++;
        if (we_addr.size() - w0 !== 3) begin
            bad++;
            $display("FAIL bw_we_count got=%0d exp=3", we_addr.size() - w0);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (we_addr[w0+k] !== ea[k] || we_data[w0+k] !== ed[k]) begin
                bad++;
                $display("FAIL bw_word%0d got=%h/%h exp=%h/%h", k,
                         we_addr[w0+k], we_data[w0+k], ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_burst_read_mode1();
        logic [31:0] r;
        logic [6:0] ea[3] = '{7'h10, 7'h11, 7'h12};
        int r0 = re_addr.size();
        int w0 = we_addr.size();
        spi_begin(2'b01);
        spi_bits(8, 32'h10, r);
        total++;
        if (r[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL br_status got=%h exp=5a", r[7:0]);
        end
        spi_bits(16, 32'h0, r);
        spi_end();
        total++;
        if (r[15:0] !== 16'hEFEE) begin
            bad++;
            $display("FAIL br_miso got=%h exp=efee", r[15:0]);
        end
        total++;
        if (re_addr.size() - r0 !== 3) begin
            bad++;
            $display("FAIL br_re_count got=%0d exp=3", re_addr.size() - r0);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (re_addr[r0+k] !== ea[k]) begin
                bad++;
                $display("FAIL br_re%0d got=%h exp=%h", k, re_addr[r0+k], ea[k]);
            end
        end
        total++;
        if ({wr_rdn, busy} !== 2'b00 || we_addr.size() != w0) begin
            bad++;
            $display("FAIL br_end got=%b%b we=%0d exp=00 we=0",
                     wr_rdn, busy, we_addr.size() - w0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        int w0 = we_addr.size();
        int f0 = ferr_n;
        spi_begin(2'b00);
        spi_bits(8, 32'h85, r);
        spi_bits(5, 32'h16, r);
        spi_end();
        total++;
        if (ferr_n - f0 !== 1 || we_addr.size() != w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort got=ferr%0d we%0d busy%b exp=ferr1 we0 busy0",
                     ferr_n - f0, we_addr.size() - w0, busy);
        end
        spi_begin(2'b00);
        spi_bits(8, 32'h85, r);
        spi_bits(8, 32'h5C, r);
        spi_end();
        total++;
        if (we_addr.size() - w0 !== 1 || ferr_n - f0 !== 1) begin
            bad++;
            $display("FAIL abort_next got=we%0d ferr%0d exp=we1 ferr1",
                     we_addr.size() - w0, ferr_n - f0);
        end
        total++;
        if (we_addr[w0] !== 7'h05 || we_data[w0] !== 8'h5C) begin
            bad++;
            $display("FAIL abort_next_we got=%h/%h exp=05/5c",
                     we_addr[w0], we_data[w0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] r;
        logic [26:0] o;
        int r0 = re_addr.size();
        int f0 = ferr_n;
        spi_begin(2'b00);
        spi_bits(8, 32'h20, r);
        spi_bits(8, 32'h0, r);
        total++;
        if (r[7:0] !== 8'hDF) begin
            bad++;
            $display("FAIL rst_word1 got=%h exp=df", r[7:0]);
        end
        spi_bits(3, 32'h0, r);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        o = {spi_miso, addr, wdata, we, re, wr_rdn, busy, frame_err, 5'b0};
        total++;
        if (o !== 27'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h exp=0", o);
        end
        spi_bits(5, 32'h1F, r);
        total++;
        if (r[4:0] !== 5'd0) begin
            bad++;
            $display("FAIL rst_miso_after got=%b exp=00000", r[4:0]);
        end
        spi_end();
        total++;
        if (re_addr.size() - r0 !== 2 || busy !== 1'b0 || ferr_n != f0) begin
            bad++;
            $display("FAIL rst_end got=re%0d busy%b ferr%0d exp=re2 busy0 ferr0",
                     re_addr.size() - r0, busy, ferr_n - f0);
        end
    endtask

    task automatic test_ena_low();
        logic [31:0] r;
        int w0 = we_addr.size();
        int r0 = re_addr.size();
        ena = 1'b0;
        spi_begin(2'b00);
        spi_bits(8, 32'h81, r);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ena_busy_mid got=%b exp=0", busy);
        end
        spi_bits(8, 32'h99, r);
        spi_end();
        ena = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (we_addr.size() != w0 || re_addr.size() != r0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ena_frozen got=we%0d re%0d busy%b exp=we0 re0 busy0",
                     we_addr.size() - w0, re_addr.size() - r0, busy);
        end
        spi_begin(2'b00);
        spi_bits(8, 32'h81, r);
        spi_bits(8, 32'h99, r);
        spi_end();
        total++;
        if (we_addr.size() - w0 !== 1 || we_addr[w0] !== 7'h01
            || we_data[w0] !== 8'h99) begin
            bad++;
            $display("FAIL ena_resume got=n%0d %h/%h exp=n1 01/99",
                     we_addr.size() - w0, we_addr[w0], we_data[w0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_mode0();
        test_burst_write_mode3();
        test_burst_read_mode1();
        test_abort();
        test_reset_mid_read();
        test_ena_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
